ysyx_23060124_bus_arbiter: RTL and testbench

YSYX_23060124_BUS_ARBITER -- requirements
Module: ysyx_23060124_bus_arbiter

---
 rtl/ysyx_23060124_bus_arbiter.sv | 139 +++++++++++++
 tb/tb_ysyx_23060124_bus_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060124_bus_arbiter.sv
// Two-master (IFU/LSU) to single-slave bus arbiter with round-robin tie-break.
// One outstanding transaction at a time; IDLE -> REQ -> RSP -> IDLE.
module ysyx_23060124_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  // IFU port
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_W-1:0]     ifu_addr,
  output logic                  ifu_rsp_valid,
  input  logic                  ifu_rsp_ready,
  output logic [DATA_W-1:0]     ifu_rdata,
  output logic                  ifu_rsp_err,
  // LSU port
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_W-1:0]     lsu_addr,
  input  logic                  lsu_wen,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [DATA_W/8-1:0]   lsu_wmask,
  output logic                  lsu_rsp_valid,
  input  logic                  lsu_rsp_ready,
  output logic [DATA_W-1:0]     lsu_rdata,
  output logic                  lsu_rsp_err,
  // memory-side port
  output logic                  slv_req_valid,
  input  logic                  slv_req_ready,
  output logic [ADDR_W-1:0]     slv_addr,
  output logic                  slv_wen,
  output logic [DATA_W-1:0]     slv_wdata,
  output logic [DATA_W/8-1:0]   slv_wmask,
  input  logic                  slv_rsp_valid,
  output logic                  slv_rsp_ready,
  input  logic [DATA_W-1:0]     slv_rdata,
  input  logic                  slv_rsp_err,
  // status
  output logic                  arb_owner,
  output logic                  arb_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_grant_q, last_grant_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;

    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    lsu_rsp_valid = 1'b0;
    ifu_rdata     = '0;
    lsu_rdata     = '0;
    ifu_rsp_err   = 1'b0;
    lsu_rsp_err   = 1'b0;
    slv_req_valid = 1'b0;
    slv_addr      = '0;
    slv_wen       = 1'b0;
    slv_wdata     = '0;
    slv_wmask     = '0;
    slv_rsp_ready = 1'b0;

    unique case (state_q)
      IDLE: begin
        // On a tie, the master that was not served last wins.
        if (ifu_req_valid && lsu_req_valid) begin
          owner_d = ~last_grant_q;
          state_d = REQ;
        end else if (ifu_req_valid) begin
          owner_d = 1'b0;
          state_d = REQ;
        end else if (lsu_req_valid) begin
          owner_d = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (owner_q) begin
          slv_req_valid = lsu_req_valid;
          slv_addr      = lsu_addr;
          slv_wen       = lsu_wen;
          slv_wdata     = lsu_wdata;
          slv_wmask     = lsu_wmask;
          lsu_req_ready = slv_req_ready;
        end else begin
          slv_req_valid = ifu_req_valid;
          slv_addr      = ifu_addr;
          ifu_req_ready = slv_req_ready;
        end
        if (slv_req_valid && slv_req_ready) state_d = RSP;
      end
      RSP: begin
        if (owner_q) begin
          lsu_rsp_valid = slv_rsp_valid;
          lsu_rdata     = slv_rdata;
          lsu_rsp_err   = slv_rsp_err;
          slv_rsp_ready = lsu_rsp_ready;
        end else begin
          ifu_rsp_valid = slv_rsp_valid;
          ifu_rdata     = slv_rdata;
          ifu_rsp_err   = slv_rsp_err;
          slv_rsp_ready = ifu_rsp_ready;
        end
        if (slv_rsp_valid && slv_rsp_ready) begin
          last_grant_d = owner_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign arb_owner = owner_q;
  assign arb_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_ysyx_23060124_bus_arbiter.sv
// Directed bench for ysyx_23060124_bus_arbiter: per-cycle vector table plus
// hand-written multi-cycle sequences (single read, alternating grants, stalls).
module tb_ysyx_23060124_bus_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic                clock;
  logic                reset;
  logic                ifu_req_valid, ifu_req_ready;
  logic [ADDR_W-1:0]   ifu_addr;
  logic                ifu_rsp_valid, ifu_rsp_ready;
  logic [DATA_W-1:0]   ifu_rdata;
  logic                ifu_rsp_err;
  logic                lsu_req_valid, lsu_req_ready;
  logic [ADDR_W-1:0]   lsu_addr;
  logic                lsu_wen;
  logic [DATA_W-1:0]   lsu_wdata;
  logic [DATA_W/8-1:0] lsu_wmask;
  logic                lsu_rsp_valid, lsu_rsp_ready;
  logic [DATA_W-1:0]   lsu_rdata;
  logic                lsu_rsp_err;
  logic                slv_req_valid, slv_req_ready;
  logic [ADDR_W-1:0]   slv_addr;
  logic                slv_wen;
  logic [DATA_W-1:0]   slv_wdata;
  logic [DATA_W/8-1:0] slv_wmask;
  logic                slv_rsp_valid, slv_rsp_ready;
  logic [DATA_W-1:0]   slv_rdata;
  logic                slv_rsp_err;
  logic                arb_owner, arb_busy;

  int checks = 0;
  int errors = 0;

  ysyx_23060124_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
    .ifu_rdata(ifu_rdata), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
    .lsu_rdata(lsu_rdata), .lsu_rsp_err(lsu_rsp_err),
    .slv_req_valid(slv_req_valid), .slv_req_ready(slv_req_ready), .slv_addr(slv_addr),
    .slv_wen(slv_wen), .slv_wdata(slv_wdata), .slv_wmask(slv_wmask),
    .slv_rsp_valid(slv_rsp_valid), .slv_rsp_ready(slv_rsp_ready),
    .slv_rdata(slv_rdata), .slv_rsp_err(slv_rsp_err),
    .arb_owner(arb_owner), .arb_busy(arb_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // inputs: rst iv lv sqr srv ser irr lrr
  // expect: busy owner sqv ird lrd ivd lvd srr ierr lerr
  typedef struct packed {
    logic [7:0] in;
    logic [9:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    slv_req_ready = 1'b0; slv_rsp_valid = 1'b0; slv_rsp_err = 1'b0;
    ifu_rsp_ready = 1'b0; lsu_rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  function automatic logic [9:0] outs();
    return {arb_busy, arb_owner, slv_req_valid, ifu_req_ready, lsu_req_ready,
            ifu_rsp_valid, lsu_rsp_valid, slv_rsp_ready, ifu_rsp_err, lsu_rsp_err};
  endfunction

  vec_t vecs[23];
  int   grants[$];
  logic ifu_rsp_seen;

  initial begin
    reset = 1'b1;
    idle_inputs();
    ifu_addr  = 32'h8000_0000;
    lsu_addr  = 32'h8000_1000;
    lsu_wen   = 1'b1;
    lsu_wdata = 32'hDEAD_BEEF;
    lsu_wmask = 4'hF;
    slv_rdata = 32'h0000_0413;
    repeat (2) step();

    vecs[0]  = {8'b1_1_1_0_0_0_0_0, 10'b0_0_0_0_0_0_0_0_0_0}; // reset held, IDLE
    vecs[1]  = {8'b0_1_1_0_0_0_0_0, 10'b0_0_0_0_0_0_0_0_0_0}; // tie -> IFU
    vecs[2]  = {8'b0_1_1_1_0_0_0_0, 10'b1_0_1_1_0_0_0_0_0_0};
    vecs[3]  = {8'b0_0_1_0_1_0_1_0, 10'b1_0_0_0_0_1_0_1_0_0};
    vecs[4]  = {8'b0_1_1_0_0_0_0_0, 10'b0_0_0_0_0_0_0_0_0_0}; // tie -> LSU
    vecs[5]  = {8'b0_1_1_1_0_0_0_0, 10'b1_1_1_0_1_0_0_0_0_0};
    vecs[6]  = {8'b0_1_1_0_1_0_1_0, 10'b1_1_0_0_0_0_1_0_0_0}; // lsu_rsp_ready low
    vecs[7]  = {8'b0_1_1_0_1_0_1_0, 10'b1_1_0_0_0_0_1_0_0_0};
    vecs[8]  = {8'b0_1_1_0_1_1_1_1, 10'b1_1_0_0_0_0_1_1_0_1};
    vecs[9]  = {8'b0_1_1_0_1_0_0_0, 10'b0_1_0_0_0_0_0_0_0_0}; // rsp ignored in IDLE
    vecs[10] = {8'b0_0_1_1_1_0_0_0, 10'b1_0_0_1_0_0_0_0_0_0}; // owner dropped valid
    vecs[11] = {8'b0_1_1_0_0_0_0_0, 10'b1_0_1_0_0_0_0_0_0_0};
    vecs[12] = {8'b0_1_1_1_0_0_0_0, 10'b1_0_1_1_0_0_0_0_0_0};
    vecs[13] = {8'b1_1_1_0_1_0_1_0, 10'b1_0_0_0_0_1_0_1_0_0}; // reset during RSP
    vecs[14] = {8'b0_1_1_0_1_0_0_0, 10'b0_0_0_0_0_0_0_0_0_0}; // tie after reset -> IFU
    vecs[15] = {8'b0_1_1_1_0_0_0_0, 10'b1_0_1_1_0_0_0_0_0_0};
    vecs[16] = {8'b0_0_0_0_0_0_1_0, 10'b1_0_0_0_0_0_0_1_0_0};
    vecs[17] = {8'b0_0_0_0_1_0_1_0, 10'b1_0_0_0_0_1_0_1_0_0};
    vecs[18] = {8'b0_0_0_0_0_0_0_0, 10'b0_0_0_0_0_0_0_0_0_0};
    vecs[19] = {8'b0_0_1_0_0_0_0_0, 10'b0_0_0_0_0_0_0_0_0_0}; // LSU only
    vecs[20] = {8'b0_0_1_1_0_0_0_0, 10'b1_1_1_0_1_0_0_0_0_0};
    vecs[21] = {8'b1_0_0_0_0_0_0_1, 10'b1_1_0_0_0_0_0_1_0_0}; // reset in RSP
    vecs[22] = {8'b0_0_0_0_1_0_1_1, 10'b0_0_0_0_0_0_0_0_0_0}; // aborted: no response

    for (int i = 0; i < 23; i++) begin
      {reset, ifu_req_valid, lsu_req_valid, slv_req_ready, slv_rsp_valid,
       slv_rsp_err, ifu_rsp_ready, lsu_rsp_ready} = vecs[i].in;
      #1;
      chk($sformatf("vec%0d", i), 64'(outs()), 64'(vecs[i].exp));
      step();
    end

    // IFU-only read
    do_reset();
    ifu_req_valid = 1'b1;
    slv_req_ready = 1'b1;
    #1;
    chk("single_idle_sqv", 64'(slv_req_valid), 64'd0);
    step();
    #1;
    chk("single_req_sqv", 64'(slv_req_valid), 64'd1);
    chk("single_req_fields", {slv_addr, slv_wen, slv_wmask, 27'd0},
        {32'h8000_0000, 1'b0, 4'h0, 27'd0});
    chk("single_req_wdata", 64'(slv_wdata), 64'd0);
    step();
    ifu_req_valid = 1'b0;
    slv_req_ready = 1'b0;
    slv_rsp_valid = 1'b1;
    ifu_rsp_ready = 1'b1;
    slv_rdata     = 32'h0000_0413;
    #1;
    chk("single_rsp_valid", 64'(ifu_rsp_valid), 64'd1);
    chk("single_rsp_rdata", 64'(ifu_rdata), 64'h413);
    chk("single_lsu_rdata_zero", 64'(lsu_rdata), 64'd0);
    step();
    slv_rsp_valid = 1'b0;
    #1;
    chk("single_busy_after", 64'(arb_busy), 64'd0);

    // Both masters request continuously; grants must alternate
    do_reset();
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    slv_req_ready = 1'b1;
    slv_rsp_valid = 1'b1;
    ifu_rsp_ready = 1'b1;
    lsu_rsp_ready = 1'b1;
    for (int c = 0; c < 20 && grants.size() < 4; c++) begin
      #1;
      if (slv_req_valid && slv_req_ready) begin
        grants.push_back(int'(arb_owner));
        if (arb_owner)
          chk("rr_lsu_fields", {slv_addr, slv_wen, slv_wmask, 27'd0},
              {32'h8000_1000, 1'b1, 4'hF, 27'd0});
        else
          chk("rr_ifu_fields", {slv_addr, slv_wen, slv_wmask, 27'd0},
              {32'h8000_0000, 1'b0, 4'h0, 27'd0});
        if (arb_owner) chk("rr_lsu_wdata", 64'(slv_wdata), 64'hDEAD_BEEF);
      end
      step();
    end
    chk("rr_grant_count", 64'(grants.size()), 64'd4);
    while (grants.size() < 4) grants.push_back(-1);
    chk("rr_order", {grants[0][0], grants[1][0], grants[2][0], grants[3][0]}, 64'b0101);
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    repeat (3) step();
    slv_rsp_valid = 1'b0;
    step();

    // LSU read with a slave stalling the request for 3 cycles, error response
    idle_inputs();
    lsu_req_valid = 1'b1;
    lsu_wen       = 1'b0;
    ifu_rsp_seen  = 1'b0;
    step();
    for (int c = 0; c < 3; c++) begin
      #1;
      ifu_rsp_seen |= ifu_rsp_valid;
      chk($sformatf("stall%0d_lsu_ready", c), {lsu_req_ready, slv_req_valid, arb_owner},
          {1'b0, 1'b1, 1'b1});
      step();
    end
    slv_req_ready = 1'b1;
    #1;
    ifu_rsp_seen |= ifu_rsp_valid;
    chk("stall_release_ready", 64'(lsu_req_ready), 64'd1);
    step();
    lsu_req_valid = 1'b0;
    slv_req_ready = 1'b0;
    slv_rsp_valid = 1'b1;
    slv_rsp_err   = 1'b1;
    slv_rdata     = 32'h1234_5678;
    lsu_rsp_ready = 1'b1;
    #1;
    ifu_rsp_seen |= ifu_rsp_valid;
    chk("err_rsp", {lsu_rsp_valid, lsu_rsp_err, ifu_rsp_err}, {1'b1, 1'b1, 1'b0});
    chk("err_rdata", 64'(lsu_rdata), 64'h1234_5678);
    step();
    slv_rsp_valid = 1'b0;
    slv_rsp_err   = 1'b0;
    #1;
    chk("err_ifu_never_valid", 64'(ifu_rsp_seen), 64'd0);
    chk("err_busy_after", 64'(arb_busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
